// File: rtl/proj1_pkg.sv
// Shared definitions for the proj1 accumulator CPU: widths, opcodes and controller state encodings.
package proj1_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_OR    = 4'd2;
   localparam logic [3:0] OP_JUMP  = 4'd3;
   localparam logic [3:0] OP_LOAD  = 4'd4;
   localparam logic [3:0] OP_STORE = 4'd5;
   localparam logic [3:0] OP_MULT  = 4'd6;

   typedef enum logic [3:0] {
      FETCH_1 = 4'd0,
      FETCH_2 = 4'd1,
      FETCH_3 = 4'd2,
      DECODE  = 4'd3,
      ADD_1   = 4'd4,
      ADD_2   = 4'd5,
      LOAD_1  = 4'd6,
      LOAD_2  = 4'd7,
      STORE   = 4'd8,
      JUMP    = 4'd9,
      OR_1    = 4'd10,
      OR_2    = 4'd11,
      MULT_1  = 4'd12,
      MULT_2  = 4'd13,
      MULT_3  = 4'd14,
      MULT_4  = 4'd15
   } state_t;

endpackage

// File: rtl/proj1_ctrl.sv
// Multicycle controller: one state per clock, branching on the opcode in Decode.
// MULT states are reachable only when PROJ1_MULT_EN is defined.
module proj1_ctrl
   import proj1_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i_opcode,
   output logic [3:0] o_state
);

   state_t present_state;
   state_t w_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) present_state <= FETCH_1;
      else     present_state <= w_next;
   end

   always_comb begin
      w_next = FETCH_1;
      case (present_state)
         FETCH_1: w_next = FETCH_2;
         FETCH_2: w_next = FETCH_3;
         FETCH_3: w_next = DECODE;
         DECODE: begin
            case (i_opcode)
               OP_ADD:   w_next = ADD_1;
               OP_OR:    w_next = OR_1;
               OP_JUMP:  w_next = JUMP;
               OP_LOAD:  w_next = LOAD_1;
               OP_STORE: w_next = STORE;
`ifdef PROJ1_MULT_EN
               OP_MULT:  w_next = MULT_1;
`endif
               default:  w_next = FETCH_1;
            endcase
         end
         ADD_1:  w_next = ADD_2;
         LOAD_1: w_next = LOAD_2;
         OR_1:   w_next = OR_2;
`ifdef PROJ1_MULT_EN
         MULT_1: w_next = MULT_2;
         MULT_2: w_next = MULT_3;
         MULT_3: w_next = MULT_4;
`endif
         default: w_next = FETCH_1;
      endcase
   end

   assign o_state = present_state;

endmodule

// File: rtl/proj1_mem.sv
// 256x16 unified instruction/data memory: combinational read, synchronous write, no reset.
module proj1_mem (
   input  logic        clk,
   input  logic        i_we,
   input  logic [7:0]  i_addr,
   input  logic [15:0] i_wdata,
   output logic [15:0] o_rdata
);

   logic [15:0] mem [0:255];

   always_ff @(posedge clk) begin
      if (i_we) mem[i_addr] <= i_wdata;
   end

   assign o_rdata = mem[i_addr];

endmodule

// File: rtl/proj1.sv
// proj1 top: accumulator CPU datapath, controller c1 and memory m1.
// Define PROJ1_MULT_EN to build the MULT instruction and its 3-stage multiplier.
module proj1
   import proj1_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic        MemRW_IO,
   output logic [7:0]  MemAddr_IO,
   output logic [15:0] MemD_IO
);

   logic [7:0]  r_pc;
   logic [7:0]  r_mar;
   logic [15:0] r_mdr;
   logic [15:0] r_ir;
   logic [15:0] r_ac;
   logic [3:0]  w_state;
   logic [15:0] w_rdata;
   logic        w_we;
   logic        w_unused_ir;

   proj1_ctrl c1 (
      .clk      (clk),
      .rst      (rst),
      .i_opcode (r_ir[15:12]),
      .o_state  (w_state)
   );

   assign w_we = (state_t'(w_state) == STORE);

   proj1_mem m1 (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (r_mar),
      .i_wdata (r_ac),
      .o_rdata (w_rdata)
   );

   assign w_unused_ir = ^r_ir[11:8];

`ifdef PROJ1_MULT_EN
   logic [15:0] w_pp [0:7];
   logic [15:0] r_s1 [0:3];
   logic [15:0] r_s2 [0:1];

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_pp[i] = r_mdr[i] ? ({8'd0, r_ac[7:0]} << i) : 16'd0;
      end
   end

   // Adder tree: 8 partial products -> 4 sums (Mult2) -> 2 sums (Mult3) -> AC (Mult4)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) r_s1[k] <= 16'd0;
         for (int k = 0; k < 2; k++) r_s2[k] <= 16'd0;
      end else begin
         if (state_t'(w_state) == MULT_2) begin
            for (int k = 0; k < 4; k++) r_s1[k] <= w_pp[2*k] + w_pp[2*k+1];
         end
         if (state_t'(w_state) == MULT_3) begin
            for (int k = 0; k < 2; k++) r_s2[k] <= r_s1[2*k] + r_s1[2*k+1];
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc  <= 8'd0;
         r_mar <= 8'd0;
         r_mdr <= 16'd0;
         r_ir  <= 16'd0;
         r_ac  <= 16'd0;
      end else begin
         case (state_t'(w_state))
            FETCH_1: r_mar <= r_pc;
            FETCH_2: begin
               r_mdr <= w_rdata;
               r_pc  <= r_pc + 8'd1;
            end
            FETCH_3: r_ir  <= r_mdr;
            DECODE:  r_mar <= r_ir[7:0];
            ADD_1, OR_1, LOAD_1: r_mdr <= w_rdata;
            ADD_2:   r_ac  <= r_ac + r_mdr;
            OR_2:    r_ac  <= r_ac | r_mdr;
            LOAD_2:  r_ac  <= r_mdr;
            JUMP:    r_pc  <= r_ir[7:0];
`ifdef PROJ1_MULT_EN
            MULT_1:  r_mdr <= w_rdata;
            MULT_4:  r_ac  <= r_s2[0] + r_s2[1];
`endif
            default: ;
         endcase
      end
   end

   assign MemRW_IO   = w_we;
   assign MemAddr_IO = r_mar;
   assign MemD_IO    = w_we ? r_ac : w_rdata;

endmodule

// File: tb/tb_proj1.sv
// Self-checking bench for proj1: state traces, register results and a write scoreboard.
module tb_proj1;

   logic        clk;
   logic        rst;
   logic        MemRW_IO;
   logic [7:0]  MemAddr_IO;
   logic [15:0] MemD_IO;

   int n_vec = 0;
   int n_err = 0;
   logic [23:0] exp_wr_q [$];

   proj1 dut (
      .clk        (clk),
      .rst        (rst),
      .MemRW_IO   (MemRW_IO),
      .MemAddr_IO (MemAddr_IO),
      .MemD_IO    (MemD_IO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Every observed memory write must match the next expected write in order
   always @(negedge clk) begin
      if (!rst && MemRW_IO) begin
         if (exp_wr_q.size() == 0) begin
            chk("wr_unexpected", {8'h00, MemAddr_IO, MemD_IO}, 32'hFFFF_FFFF);
         end else begin
            logic [23:0] e;
            e = exp_wr_q.pop_front();
            chk("wr_addr", {24'd0, MemAddr_IO}, {24'd0, e[23:16]});
            chk("wr_data", {16'd0, MemD_IO}, {16'd0, e[15:0]});
         end
      end
   end

   task automatic clear_mem();
      rst = 1'b1;
      for (int i = 0; i < 256; i++) dut.m1.mem[i] = 16'h0000;
   endtask

   task automatic set_word(input logic [7:0] a, input logic [15:0] d);
      dut.m1.mem[a] = d;
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic steps(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Each hex digit is the expected present_state at successive negedges
   task automatic run_trace(input string tr, input string tag);
      for (int i = 0; i < tr.len(); i++) begin
         int c;
         int e;
         c = tr[i];
         e = (c >= 97) ? c - 87 : c - 48;
         chk(tag, {28'd0, dut.c1.present_state}, e);
         @(negedge clk);
      end
   endtask

   task automatic load_add_store_prog();
      clear_mem();
      set_word(8'h00, 16'h400A);
      set_word(8'h01, 16'h100B);
      set_word(8'h02, 16'h500D);
      set_word(8'h0A, 16'h0005);
      set_word(8'h0B, 16'h0007);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      #20;
      chk("rst_state", {28'd0, dut.c1.present_state}, 0);
      chk("rst_pc", {24'd0, dut.r_pc}, 0);
      chk("rst_ac", {16'd0, dut.r_ac}, 0);
      chk("rst_memrw", {31'd0, MemRW_IO}, 0);

      // LOAD / ADD / STORE
      load_add_store_prog();
      exp_wr_q.push_back({8'h0D, 16'h000C});
      release_rst();
      run_trace("01236701234501238", "las_state");
      chk("las_mem0d", {16'd0, dut.m1.mem[8'h0D]}, 32'h000C);
      chk("las_wr_missing", exp_wr_q.size(), 0);

      // OR / JUMP loop
      clear_mem();
      set_word(8'h00, 16'h400A);
      set_word(8'h01, 16'h200B);
      set_word(8'h02, 16'h3000);
      set_word(8'h0A, 16'h00F0);
      set_word(8'h0B, 16'h000F);
      release_rst();
      steps(12);
      chk("or_ac", {16'd0, dut.r_ac}, 32'h00FF);
      steps(4);
      chk("jump_state", {28'd0, dut.c1.present_state}, 9);
      chk("jump_pc_before", {24'd0, dut.r_pc}, 3);
      steps(1);
      chk("jump_pc_after", {24'd0, dut.r_pc}, 0);
      steps(6);
      chk("loop_reload_ac", {16'd0, dut.r_ac}, 32'h00F0);

      // MULT (or NOP when the multiplier is not built)
      clear_mem();
      set_word(8'h00, 16'h400A);
      set_word(8'h01, 16'h600B);
      set_word(8'h02, 16'h500D);
      set_word(8'h0A, 16'h00FF);
      set_word(8'h0B, 16'h00FF);
`ifdef PROJ1_MULT_EN
      exp_wr_q.push_back({8'h0D, 16'hFE01});
      release_rst();
      run_trace("0123670123cdef01238", "mult_state");
      chk("mult_mem0d", {16'd0, dut.m1.mem[8'h0D]}, 32'hFE01);
`else
      exp_wr_q.push_back({8'h0D, 16'h00FF});
      release_rst();
      run_trace("012367012301238", "mult_nop_state");
      chk("mult_nop_mem0d", {16'd0, dut.m1.mem[8'h0D]}, 32'h00FF);
`endif
      chk("mult_wr_missing", exp_wr_q.size(), 0);

      // ADD overflow wraps modulo 2^16
      clear_mem();
      set_word(8'h00, 16'h400A);
      set_word(8'h01, 16'h100B);
      set_word(8'h0A, 16'hFFFF);
      set_word(8'h0B, 16'h0002);
      release_rst();
      steps(12);
      chk("add_wrap_ac", {16'd0, dut.r_ac}, 32'h0001);

      // PC wraps from 0xFF to 0x00
      clear_mem();
      set_word(8'h00, 16'h30FF);
      set_word(8'hFF, 16'h4010);
      set_word(8'h10, 16'hABCD);
      release_rst();
      steps(5);
      chk("wrap_pc_ff", {24'd0, dut.r_pc}, 32'hFF);
      steps(2);
      chk("wrap_pc_00", {24'd0, dut.r_pc}, 0);
      chk("wrap_mar", {24'd0, MemAddr_IO}, 32'hFF);
      steps(4);
      chk("wrap_load_ac", {16'd0, dut.r_ac}, 32'hABCD);

      // Unknown opcode is a NOP: AC unchanged, no write
      clear_mem();
      set_word(8'h00, 16'h400A);
      set_word(8'h01, 16'hF000);
      set_word(8'h02, 16'h500D);
      set_word(8'h0A, 16'h1234);
      exp_wr_q.push_back({8'h0D, 16'h1234});
      release_rst();
      run_trace("01236701230", "nop_state");
      chk("nop_ac", {16'd0, dut.r_ac}, 32'h1234);
      run_trace("1238", "nop_store_state");
      chk("nop_mem0d", {16'd0, dut.m1.mem[8'h0D]}, 32'h1234);
      chk("nop_wr_missing", exp_wr_q.size(), 0);

      // Reset asserted during Add1
      load_add_store_prog();
      release_rst();
      steps(10);
      chk("pre_rst_state", {28'd0, dut.c1.present_state}, 4);
      rst = 1'b1;
      #1;
      chk("mid_rst_state", {28'd0, dut.c1.present_state}, 0);
      chk("mid_rst_pc", {24'd0, dut.r_pc}, 0);
      chk("mid_rst_ac", {16'd0, dut.r_ac}, 0);
      chk("mid_rst_memrw", {31'd0, MemRW_IO}, 0);
      chk("mid_rst_addr", {24'd0, MemAddr_IO}, 0);
      chk("mid_rst_memd", {16'd0, MemD_IO}, 32'h400A);
      chk("mid_rst_mem0b", {16'd0, dut.m1.mem[8'h0B]}, 32'h0007);
      release_rst();
      run_trace("012367", "post_rst_state");
      chk("post_rst_ac", {16'd0, dut.r_ac}, 32'h0005);

      // Reset asserted during Store aborts the write
      load_add_store_prog();
      release_rst();
      steps(15);
      @(posedge clk);
      #1;
      chk("pre_abort_state", {28'd0, dut.c1.present_state}, 8);
      rst = 1'b1;
      #1;
      chk("abort_memrw", {31'd0, MemRW_IO}, 0);
      @(negedge clk);
      @(negedge clk);
      chk("abort_mem0d", {16'd0, dut.m1.mem[8'h0D]}, 0);
      chk("final_wr_missing", exp_wr_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
